// File: rtl/chacha_keystream_xor.sv
// XORs a plaintext word stream with 512-bit keystream blocks serialized into words.
// Define CHACHA_KS_PREFETCH_EN for a two-entry keystream buffer with no bubble between blocks.
module chacha_keystream_xor #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned WORD_W = 32
) (
    input  logic              aclk,
    input  logic              srst,
    input  logic              ks_tvalid,
    output logic              ks_tready,
    input  logic [DATA_W-1:0] ks_tdata,
    input  logic              pt_tvalid,
    output logic              pt_tready,
    input  logic [WORD_W-1:0] pt_tdata,
    input  logic              pt_tlast,
    output logic              ct_tvalid,
    input  logic              ct_tready,
    output logic [WORD_W-1:0] ct_tdata,
    output logic              ct_tlast
);

    localparam int unsigned NWORDS = DATA_W / WORD_W;
    localparam int unsigned IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    logic [DATA_W-1:0] blk0_q, blk0_d;
    logic              buf_valid_q, buf_valid_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ct_valid_d, ct_last_d;
    logic [WORD_W-1:0] ct_data_d;
    logic [WORD_W-1:0] cur_word;
    logic              ks_hs, pt_hs, blk_done;

`ifdef CHACHA_KS_PREFETCH_EN
    logic [DATA_W-1:0] blk1_q, blk1_d;
    logic              nxt_valid_q, nxt_valid_d;

    assign ks_tready = !srst && !(buf_valid_q && nxt_valid_q);
`else
    assign ks_tready = !srst && !buf_valid_q;
`endif

    assign pt_tready = !srst && buf_valid_q && (!ct_tvalid || ct_tready);
    assign ks_hs     = ks_tvalid && ks_tready;
    assign pt_hs     = pt_tvalid && pt_tready;
    assign cur_word  = blk0_q[idx_q*WORD_W +: WORD_W];
    assign blk_done  = (idx_q == LAST_IDX) || pt_tlast;

    always_comb begin
        blk0_d      = blk0_q;
        buf_valid_d = buf_valid_q;
        idx_d       = idx_q;
        ct_valid_d  = ct_tvalid;
        ct_data_d   = ct_tdata;
        ct_last_d   = ct_tlast;
`ifdef CHACHA_KS_PREFETCH_EN
        blk1_d      = blk1_q;
        nxt_valid_d = nxt_valid_q;
`endif

        if (pt_hs) begin
            ct_valid_d = 1'b1;
            ct_data_d  = pt_tdata ^ cur_word;
            ct_last_d  = pt_tlast;
            if (blk_done) begin
                idx_d = '0;
`ifdef CHACHA_KS_PREFETCH_EN
                // Promote the prefetched block so the next word sees it without a bubble.
                blk0_d      = blk1_q;
                buf_valid_d = nxt_valid_q;
                nxt_valid_d = 1'b0;
`else
                buf_valid_d = 1'b0;
`endif
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (ct_tready) begin
            ct_valid_d = 1'b0;
        end

        if (ks_hs) begin
`ifdef CHACHA_KS_PREFETCH_EN
            // Evaluated after promotion, so a coincident block lands in the freed slot.
            if (!buf_valid_d) begin
                blk0_d      = ks_tdata;
                buf_valid_d = 1'b1;
                idx_d       = '0;
            end else begin
                blk1_d      = ks_tdata;
                nxt_valid_d = 1'b1;
            end
`else
            blk0_d      = ks_tdata;
            buf_valid_d = 1'b1;
            idx_d       = '0;
`endif
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            buf_valid_q <= 1'b0;
            idx_q       <= '0;
            ct_tvalid   <= 1'b0;
            ct_tdata    <= '0;
            ct_tlast    <= 1'b0;
`ifdef CHACHA_KS_PREFETCH_EN
            nxt_valid_q <= 1'b0;
`endif
        end else begin
            buf_valid_q <= buf_valid_d;
            idx_q       <= idx_d;
            ct_tvalid   <= ct_valid_d;
            ct_tdata    <= ct_data_d;
            ct_tlast    <= ct_last_d;
`ifdef CHACHA_KS_PREFETCH_EN
            nxt_valid_q <= nxt_valid_d;
`endif
        end
    end

    // Block storage needs no reset; it is qualified by the valid flags.
    always_ff @(posedge aclk) begin
        blk0_q <= blk0_d;
`ifdef CHACHA_KS_PREFETCH_EN
        blk1_q <= blk1_d;
`endif
    end

endmodule

// File: tb/tb_chacha_keystream_xor.sv
// Randomized and directed bench for chacha_keystream_xor against a word-pointer reference model.
module tb_chacha_keystream_xor;

    localparam int unsigned DATA_W = 512;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned NW     = DATA_W / WORD_W;

    logic              aclk = 1'b0;
    logic              srst;
    logic              ks_tvalid, ks_tready;
    logic [DATA_W-1:0] ks_tdata;
    logic              pt_tvalid, pt_tready, pt_tlast;
    logic [WORD_W-1:0] pt_tdata;
    logic              ct_tvalid, ct_tready, ct_tlast;
    logic [WORD_W-1:0] ct_tdata;

    always #5 aclk = ~aclk;

    chacha_keystream_xor #(.DATA_W(DATA_W), .WORD_W(WORD_W)) dut (
        .aclk      (aclk),
        .srst      (srst),
        .ks_tvalid (ks_tvalid),
        .ks_tready (ks_tready),
        .ks_tdata  (ks_tdata),
        .pt_tvalid (pt_tvalid),
        .pt_tready (pt_tready),
        .pt_tdata  (pt_tdata),
        .pt_tlast  (pt_tlast),
        .ct_tvalid (ct_tvalid),
        .ct_tready (ct_tready),
        .ct_tdata  (ct_tdata),
        .ct_tlast  (ct_tlast)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [DATA_W-1:0] blk_q[$];
    logic [WORD_W-1:0] pt_q[$];
    bit                last_q[$];
    logic [WORD_W:0]   exp_q[$];
    logic [WORD_W:0]   ct_log[$];
    int                pt_hs_cyc[$], ks_hs_cyc[$], ct_hs_cyc[$];

    int pt_gap_pct = 0;
    int ks_gap_pct = 0;
    int rdy_pct    = 100;
    bit rdy_manual = 1'b1;

    logic [DATA_W-1:0] kb;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_block();
        logic [DATA_W-1:0] b;
        for (int i = 0; i < NW; i++) b[i*WORD_W +: WORD_W] = $urandom();
        return b;
    endfunction

    task automatic clear_run();
        blk_q.delete(); pt_q.delete(); last_q.delete(); exp_q.delete(); ct_log.delete();
        pt_hs_cyc.delete(); ks_hs_cyc.delete(); ct_hs_cyc.delete();
    endtask

    task automatic add_msg(input int len);
        for (int i = 0; i < len; i++) begin
            pt_q.push_back($urandom());
            last_q.push_back(i == len - 1);
        end
    endtask

    // Reference: each word uses the next unused keystream word; a block is retired when
    // all its words are used or the message ends.
    task automatic compute_expected();
        int b = 0;
        int p = 0;
        logic [DATA_W-1:0] blk;
        exp_q.delete();
        for (int k = 0; k < pt_q.size(); k++) begin
            if (b >= blk_q.size()) blk_q.push_back(rand_block());
            blk = blk_q[b];
            exp_q.push_back({last_q[k], pt_q[k] ^ blk[p*WORD_W +: WORD_W]});
            if (last_q[k] || p == NW - 1) begin
                b++;
                p = 0;
            end else begin
                p++;
            end
        end
    endtask

    task automatic drive_ks();
        bit hs;
        for (int i = 0; i < blk_q.size(); i++) begin
            if ($urandom_range(99) < ks_gap_pct)
                repeat ($urandom_range(1, 4)) begin @(posedge aclk); #1; end
            ks_tvalid = 1'b1;
            ks_tdata  = blk_q[i];
            hs = 1'b0;
            while (!hs) begin
                @(negedge aclk);
                hs = ks_tready;
                if (hs) ks_hs_cyc.push_back(cyc);
                @(posedge aclk); #1;
            end
            ks_tvalid = 1'b0;
            ks_tdata  = 'x;
        end
    endtask

    task automatic drive_pt();
        bit hs;
        for (int k = 0; k < pt_q.size(); k++) begin
            if ($urandom_range(99) < pt_gap_pct)
                repeat ($urandom_range(1, 3)) begin @(posedge aclk); #1; end
            pt_tvalid = 1'b1;
            pt_tdata  = pt_q[k];
            pt_tlast  = last_q[k];
            hs = 1'b0;
            while (!hs) begin
                @(negedge aclk);
                hs = pt_tready;
                if (hs) pt_hs_cyc.push_back(cyc);
                @(posedge aclk); #1;
            end
            pt_tvalid = 1'b0;
            pt_tdata  = 'x;
            pt_tlast  = 1'b0;
        end
    endtask

    task automatic run_traffic(input bit bp, input bit rst_mid);
        compute_expected();
        fork
            drive_ks();
            drive_pt();
            begin
                if (bp) begin
                    while (ct_hs_cyc.size() < 5) @(posedge aclk);
                    #1 ct_tready = 1'b0;
                    repeat (5) @(posedge aclk);
                    #1 ct_tready = 1'b1;
                end
            end
        join
        if (rst_mid) begin
            srst = 1'b1;
            @(negedge aclk);
            check_eq("rst_ks_tready", ks_tready, 1'b0);
            check_eq("rst_pt_tready", pt_tready, 1'b0);
            @(posedge aclk); #1;
            srst = 1'b0;
            @(negedge aclk);
            check_eq("rst_ct_tvalid", ct_tvalid, 1'b0);
            check_eq("rst_ks_tready_after", ks_tready, 1'b1);
            check_eq("rst_pt_tready_after", pt_tready, 1'b0);
        end else begin
            for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge aclk);
        end
        check_eq("drain", exp_q.size(), 0);
        @(posedge aclk); #1;
    endtask

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    initial forever begin
        @(posedge aclk); #1;
        if (!rdy_manual) ct_tready = ($urandom_range(99) < rdy_pct);
    end

    // Output monitor: scoreboard on handshakes, stability and pt_tready while stalled.
    initial begin
        logic [WORD_W:0] stall_word;
        bit              stall_prev;
        stall_prev = 1'b0;
        stall_word = '0;
        forever begin
            @(negedge aclk);
            if (ct_tvalid && ct_tready) begin
                ct_hs_cyc.push_back(cyc);
                ct_log.push_back({ct_tlast, ct_tdata});
                if (exp_q.size() != 0) check_eq("ct_word", {ct_tlast, ct_tdata}, exp_q.pop_front());
                else check_eq("ct_unexpected", ct_tvalid, 1'b0);
            end
            if (ct_tvalid && !ct_tready) begin
                check_eq("bp_pt_tready", pt_tready, 1'b0);
                if (stall_prev) check_eq("bp_hold", {ct_tlast, ct_tdata}, stall_word);
                stall_prev = 1'b1;
                stall_word = {ct_tlast, ct_tdata};
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        srst      = 1'b1;
        ks_tvalid = 1'b0;
        ks_tdata  = '0;
        pt_tvalid = 1'b0;
        pt_tdata  = '0;
        pt_tlast  = 1'b0;
        ct_tready = 1'b1;

        for (int i = 0; i < NW; i++) kb[i*WORD_W +: WORD_W] = 32'h9a000000 + i;
        kb[0*WORD_W +: WORD_W]  = 32'he4e7f110;
        kb[1*WORD_W +: WORD_W]  = 32'h15593bd1;
        kb[14*WORD_W +: WORD_W] = 32'he883d0cb;
        kb[15*WORD_W +: WORD_W] = 32'h4e3c50a2;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_eq("reset_ks_tready", ks_tready, 1'b0);
        check_eq("reset_pt_tready", pt_tready, 1'b0);
        check_eq("reset_ct_tvalid", ct_tvalid, 1'b0);
        check_eq("reset_ct_tdata", ct_tdata, 32'h0);
        check_eq("reset_ct_tlast", ct_tlast, 1'b0);
        @(posedge aclk); #1;
        srst = 1'b0;
        @(negedge aclk);
        check_eq("idle_ks_tready", ks_tready, 1'b1);
        check_eq("idle_pt_tready", pt_tready, 1'b0);
        @(posedge aclk); #1;

        // Zero plaintext over one block, full throughput.
        clear_run();
        blk_q.push_back(kb);
        for (int i = 0; i < NW; i++) begin
            pt_q.push_back(32'h0);
            last_q.push_back(i == NW - 1);
        end
        run_traffic(1'b0, 1'b0);
        check_eq("zero_word0", ct_log[0], {1'b0, 32'he4e7f110});
        check_eq("zero_word1", ct_log[1], {1'b0, 32'h15593bd1});
        check_eq("zero_word15", ct_log[15], {1'b1, 32'h4e3c50a2});
        check_eq("zero_stream_cycles", ct_hs_cyc[15] - ct_hs_cyc[0], 15);
        check_eq("zero_latency", ct_hs_cyc[0] - pt_hs_cyc[0], 1);

        // Inversion.
        clear_run();
        blk_q.push_back(kb);
        pt_q.push_back(32'hffffffff);
        last_q.push_back(1'b1);
        run_traffic(1'b0, 1'b0);
        check_eq("inv_word0", ct_log[0], {1'b1, 32'h1b180eef});
        check_eq("inv_latency", ct_hs_cyc[0] - pt_hs_cyc[0], 1);

        // Early tlast: remainder of block 0 dropped.
        clear_run();
        blk_q.push_back(kb);
        blk_q.push_back(rand_block());
        add_msg(3);
        add_msg(1);
        run_traffic(1'b0, 1'b0);
`ifdef CHACHA_KS_PREFETCH_EN
        check_eq("early_ks_prefetch", ks_hs_cyc[1] - ks_hs_cyc[0], 1);
`else
        check_eq("early_ks_after_word2", ks_hs_cyc[1] - pt_hs_cyc[2], 1);
`endif

        // Backpressure mid-block.
        clear_run();
        blk_q.push_back(kb);
        add_msg(NW);
        run_traffic(1'b1, 1'b0);
        check_eq("bp_word_count", ct_log.size(), NW);

        // Multi-block stream.
        clear_run();
        add_msg(40);
        run_traffic(1'b0, 1'b0);
        check_eq("multi_inblock_gap", pt_hs_cyc[1] - pt_hs_cyc[0], 1);
`ifdef CHACHA_KS_PREFETCH_EN
        check_eq("multi_gap_b1", pt_hs_cyc[16] - pt_hs_cyc[15], 1);
        check_eq("multi_gap_b2", pt_hs_cyc[32] - pt_hs_cyc[31], 1);
`else
        check_eq("multi_gap_b1", pt_hs_cyc[16] - pt_hs_cyc[15], 2);
        check_eq("multi_gap_b2", pt_hs_cyc[32] - pt_hs_cyc[31], 2);
`endif

        // Reset after word 7, then a fresh block starts at word 0.
        clear_run();
        for (int i = 0; i < 8; i++) begin
            pt_q.push_back($urandom());
            last_q.push_back(1'b0);
        end
        run_traffic(1'b0, 1'b1);
        check_eq("rst_words_out", ct_log.size(), 8);
        clear_run();
        add_msg(4);
        run_traffic(1'b0, 1'b0);

        // Randomized traffic.
        rdy_manual = 1'b0;
        for (int r = 0; r < 8; r++) begin
            pt_gap_pct = $urandom_range(0, 40);
            ks_gap_pct = $urandom_range(0, 40);
            rdy_pct    = $urandom_range(50, 100);
            clear_run();
            repeat ($urandom_range(1, 5)) add_msg($urandom_range(1, 40));
            run_traffic(1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
